// File: rtl/cva6_hpdcache_tcm_responder.sv
// cva6_hpdcache_tcm_responder: scratchpad answering the HPDcache request/response
// protocol. Three stages: S0 accept, S1 resolve + array access, S2 registered response.
// Optional feature macro: HPDCACHE_TCM_AMO_EN (AMO datapath and LR/SC reservation).
// The package below carries the minimal HPDcache types this block consumes.

package hpdcache_pkg;
    localparam int unsigned HPDCACHE_TAG_WIDTH        = 28;
    localparam int unsigned HPDCACHE_REQ_OFFSET_WIDTH = 12;

    typedef logic [HPDCACHE_TAG_WIDTH-1:0]        hpdcache_tag_t;
    typedef logic [HPDCACHE_REQ_OFFSET_WIDTH-1:0] hpdcache_req_offset_t;

    typedef enum logic [3:0] {
        HPDCACHE_REQ_LOAD     = 4'h0,
        HPDCACHE_REQ_STORE    = 4'h1,
        HPDCACHE_REQ_AMO_LR   = 4'h4,
        HPDCACHE_REQ_AMO_SC   = 4'h5,
        HPDCACHE_REQ_AMO_SWAP = 4'h6,
        HPDCACHE_REQ_AMO_ADD  = 4'h7,
        HPDCACHE_REQ_AMO_AND  = 4'h8,
        HPDCACHE_REQ_AMO_OR   = 4'h9,
        HPDCACHE_REQ_AMO_XOR  = 4'ha,
        HPDCACHE_REQ_AMO_MAX  = 4'hb,
        HPDCACHE_REQ_AMO_MAXU = 4'hc,
        HPDCACHE_REQ_AMO_MIN  = 4'hd,
        HPDCACHE_REQ_AMO_MINU = 4'he,
        HPDCACHE_REQ_CMO      = 4'hf
    } hpdcache_req_op_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        hpdcache_req_offset_t addr_offset;
        logic [63:0]          wdata;
        hpdcache_req_op_t     op;
        logic [7:0]           be;
        logic [2:0]           size;
        logic [2:0]           sid;
        logic [7:0]           tid;
        logic                 need_rsp;
        logic                 phys_indexed;
        hpdcache_tag_t        addr_tag;
        hpdcache_pma_t        pma;
    } hpdcache_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic [2:0]  sid;
        logic [7:0]  tid;
        logic        error;
    } hpdcache_rsp_t;
endpackage

module cva6_hpdcache_tcm_responder
    import hpdcache_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = HPDCACHE_TAG_WIDTH + HPDCACHE_REQ_OFFSET_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hpdcache_req_valid_i,
    output logic          hpdcache_req_ready_o,
    input  hpdcache_req_t hpdcache_req_i,
    input  logic          hpdcache_req_abort_i,
    input  hpdcache_tag_t hpdcache_req_tag_i,
    output logic          hpdcache_rsp_valid_o,
    output hpdcache_rsp_t hpdcache_rsp_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    function automatic logic [63:0] byte_merge(input logic [63:0] old_w,
                                               input logic [63:0] new_w,
                                               input logic [7:0]  be);
        logic [63:0] res;
        for (int b = 0; b < 8; b++)
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

`ifdef HPDCACHE_TCM_AMO_EN
    // 32-bit AMOs operate on the half picked by be[4]; the other half passes through.
    function automatic logic [63:0] amo_calc(input hpdcache_req_op_t op,
                                             input logic [63:0] old_w,
                                             input logic [63:0] opnd,
                                             input logic        w32,
                                             input logic        hi);
        logic [31:0] a32, b32;
        logic [63:0] a, b, as, bs, r;
        a32 = hi ? old_w[63:32] : old_w[31:0];
        b32 = hi ? opnd[63:32]  : opnd[31:0];
        a   = w32 ? {32'd0, a32} : old_w;
        b   = w32 ? {32'd0, b32} : opnd;
        as  = w32 ? {{32{a32[31]}}, a32} : old_w;
        bs  = w32 ? {{32{b32[31]}}, b32} : opnd;
        case (op)
            HPDCACHE_REQ_AMO_SWAP: r = b;
            HPDCACHE_REQ_AMO_ADD:  r = a + b;
            HPDCACHE_REQ_AMO_AND:  r = a & b;
            HPDCACHE_REQ_AMO_OR:   r = a | b;
            HPDCACHE_REQ_AMO_XOR:  r = a ^ b;
            HPDCACHE_REQ_AMO_MAX:  r = ($signed(as) > $signed(bs)) ? a : b;
            HPDCACHE_REQ_AMO_MAXU: r = (a > b) ? a : b;
            HPDCACHE_REQ_AMO_MIN:  r = ($signed(as) < $signed(bs)) ? a : b;
            HPDCACHE_REQ_AMO_MINU: r = (a < b) ? a : b;
            default:               r = a;
        endcase
        if (w32) return hi ? {r[31:0], old_w[31:0]} : {old_w[63:32], r[31:0]};
        return r;
    endfunction
`endif

    logic          s1_vld;
    hpdcache_req_t s1_req;
    logic [ADDR_W-1:0] s1_addr;
    logic [IDX_W-1:0]  s1_idx;
    logic          s1_oor;
    logic          s1_live;
    logic [63:0]   mem [DEPTH];
    logic [63:0]   rd_word;
    logic          wr_en;
    logic [63:0]   wr_data;
    logic          mem_we;
    logic          rsp_err;
    logic [63:0]   rsp_data;
    logic          rsp_fire;
    logic          accept;
    logic          tcm_unused;

    assign hpdcache_req_ready_o = !rst_i;
    assign accept = hpdcache_req_valid_i && hpdcache_req_ready_o;

    // Virtually-indexed requests take their tag from the late tag port during S1.
    assign s1_addr = s1_req.phys_indexed ?
                     ADDR_W'({s1_req.addr_tag, s1_req.addr_offset}) :
                     ADDR_W'({hpdcache_req_tag_i, s1_req.addr_offset});
    assign s1_idx  = s1_addr[3 +: IDX_W];
    assign s1_oor  = |s1_addr[ADDR_W-1:3+IDX_W];
    assign s1_live = s1_vld && !(hpdcache_req_abort_i && !s1_req.phys_indexed);
    assign rd_word = mem[s1_idx];
    assign mem_we  = s1_live && wr_en;
    assign rsp_fire = s1_live && (s1_req.need_rsp || rsp_err);

    assign tcm_unused = ^{s1_req.pma, s1_req.size};

`ifdef HPDCACHE_TCM_AMO_EN
    logic             resv_vld;
    logic [IDX_W-1:0] resv_idx;
    logic             sc_ok;
    assign sc_ok = resv_vld && (resv_idx == s1_idx);

    // Reservation: LR sets, SC always clears, any write to the reserved word clears.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resv_vld <= 1'b0;
            resv_idx <= '0;
        end else if (s1_live) begin
            if (s1_req.op == HPDCACHE_REQ_AMO_SC) begin
                resv_vld <= 1'b0;
            end else if (s1_req.op == HPDCACHE_REQ_AMO_LR && !s1_oor) begin
                resv_vld <= 1'b1;
                resv_idx <= s1_idx;
            end else if (mem_we && s1_idx == resv_idx) begin
                resv_vld <= 1'b0;
            end
        end
    end
`endif

    // S1 op decode: write enable, write data, response data and error.
    always_comb begin
        wr_en    = 1'b0;
        wr_data  = rd_word;
        rsp_err  = 1'b0;
        rsp_data = '0;
        if (s1_oor) begin
            rsp_err = 1'b1;
        end else begin
            case (s1_req.op)
                HPDCACHE_REQ_LOAD: rsp_data = rd_word;
                HPDCACHE_REQ_STORE: begin
                    wr_en   = 1'b1;
                    wr_data = byte_merge(rd_word, s1_req.wdata, s1_req.be);
                end
`ifdef HPDCACHE_TCM_AMO_EN
                HPDCACHE_REQ_AMO_LR: rsp_data = rd_word;
                HPDCACHE_REQ_AMO_SC: begin
                    if (sc_ok) begin
                        wr_en   = 1'b1;
                        wr_data = byte_merge(rd_word, s1_req.wdata, s1_req.be);
                    end else begin
                        rsp_data = 64'd1;
                    end
                end
                HPDCACHE_REQ_AMO_SWAP, HPDCACHE_REQ_AMO_ADD, HPDCACHE_REQ_AMO_AND,
                HPDCACHE_REQ_AMO_OR, HPDCACHE_REQ_AMO_XOR, HPDCACHE_REQ_AMO_MAX,
                HPDCACHE_REQ_AMO_MAXU, HPDCACHE_REQ_AMO_MIN, HPDCACHE_REQ_AMO_MINU: begin
                    wr_en    = 1'b1;
                    wr_data  = amo_calc(s1_req.op, rd_word, s1_req.wdata,
                                        s1_req.size != 3'd3, s1_req.be[4]);
                    rsp_data = rd_word;
                end
`endif
                default: rsp_err = 1'b1;
            endcase
        end
    end

    // S0 -> S1 capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld <= 1'b0;
            s1_req <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) s1_req <= hpdcache_req_i;
        end
    end

    // Array write at the end of S1; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[s1_idx] <= wr_data;
    end

    // S2 registered response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hpdcache_rsp_valid_o <= 1'b0;
            hpdcache_rsp_o       <= '0;
        end else begin
            hpdcache_rsp_valid_o <= rsp_fire;
            if (rsp_fire) begin
                hpdcache_rsp_o.rdata <= rsp_data;
                hpdcache_rsp_o.sid   <= s1_req.sid;
                hpdcache_rsp_o.tid   <= s1_req.tid;
                hpdcache_rsp_o.error <= rsp_err;
            end
        end
    end
endmodule
